// File: rtl/bit_serial_adder_if.sv
// bit_serial_adder_if: operand/result handshake bundle; overflow exists only with BIT_SERIAL_ADDER_OVF_EN.
interface bit_serial_adder_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    logic             overflow;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, sum, carry_out, overflow);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, sum, carry_out, overflow);
`else
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, sum, carry_out);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, sum, carry_out);
`endif
endinterface

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial adder, one bit per clock; BIT_SERIAL_ADDER_OVF_EN adds signed overflow.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    bit_serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, co_q, co_d, s, c_nxt, last;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif
    always_comb begin
        s       = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        c_nxt   = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
        last    = cnt_q == CW'(WIDTH - 1);
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        co_d    = co_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (state_q == IDLE && bus.in_valid) begin
            a_sh_d  = bus.a;
            b_sh_d  = bus.b;
            cnt_d   = '0;
            c_d     = 1'b0;
            state_d = RUN;
        end
        if (state_q == RUN) begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = {s, res_q[WIDTH-1:1]};
            cnt_d  = cnt_q + 1'b1;
            c_d    = c_nxt;
            if (last) begin
                sum_d   = {s, res_q[WIDTH-1:1]};
                co_d    = c_nxt;
`ifdef BIT_SERIAL_ADDER_OVF_EN
                // c_q is the carry into the MSB on this final edge
                ovf_d   = c_q ^ c_nxt;
`endif
                state_d = DONE;
            end
        end
        if (state_q == DONE && bus.out_ready) state_d = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            co_q    <= co_d;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.sum       = sum_q;
    assign bus.carry_out = co_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    assign bus.overflow  = ovf_q;
`endif
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: directed checks of handshake timing, sums, backpressure, reset abort and streaming.
module tb_bit_serial_adder;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    bit_serial_adder_if #(.WIDTH(W)) bus ();
    bit_serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] es,
                         input logic ec, input logic eo);
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("in_ready_drop", 64'(bus.in_ready), 64'(1'b0));
        repeat (W - 1) tick();
        check("lat_early", 64'(bus.out_valid), 64'(1'b0));
        tick();
        check("lat_valid", 64'(bus.out_valid), 64'(1'b1));
        check("sum", 64'(bus.sum), 64'(es));
        check("carry_out", 64'(bus.carry_out), 64'(ec));
`ifdef BIT_SERIAL_ADDER_OVF_EN
        check("overflow", 64'(bus.overflow), 64'(eo));
`else
        if (eo === 1'bx) $display("unreachable");
`endif
        tick();
        check("ret_valid", 64'(bus.out_valid), 64'(1'b0));
        check("ret_ready", 64'(bus.in_ready), 64'(1'b1));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int start, n;
        logic [W-1:0] ra, rb;
        logic seen;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
        check("rst_sum", 64'(bus.sum), 64'(0));
        check("rst_carry", 64'(bus.carry_out), 64'(0));
        do_op(8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        do_op(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        do_op(8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
        // backpressure: result must hold while a new request is refused
        bus.out_ready = 1'b0;
        bus.a = 8'h12;
        bus.b = 8'h34;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (W) tick();
        check("bp_valid_rise", 64'(bus.out_valid), 64'(1'b1));
        bus.a = 8'h01;
        bus.b = 8'h01;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 64'(bus.out_valid), 64'(1'b1));
            check("bp_hold_sum", 64'(bus.sum), 64'(8'h46));
            check("bp_refuse", 64'(bus.in_ready), 64'(1'b0));
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(bus.out_valid), 64'(1'b0));
        check("bp_release_ready", 64'(bus.in_ready), 64'(1'b1));
        tick();
        bus.in_valid = 1'b0;
        check("bp_next_accept", 64'(bus.in_ready), 64'(1'b0));
        repeat (W) tick();
        check("bp_next_valid", 64'(bus.out_valid), 64'(1'b1));
        check("bp_next_sum", 64'(bus.sum), 64'(8'h02));
        tick();
        // reset three cycles into an operation
        bus.a = 8'hAA;
        bus.b = 8'h55;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 64'(bus.in_ready), 64'(1'b1));
        check("abort_out_valid", 64'(bus.out_valid), 64'(1'b0));
        check("abort_sum", 64'(bus.sum), 64'(0));
        check("abort_carry", 64'(bus.carry_out), 64'(0));
        seen = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            seen = seen | bus.out_valid;
        end
        check("abort_no_valid", 64'(seen), 64'(1'b0));
        do_op(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
        // streaming with both handshakes tied high
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        start = 0;
        for (int k = 0; k < 20; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            bus.a = ra;
            bus.b = rb;
            check("b2b_ready", 64'(bus.in_ready), 64'(1'b1));
            tick();
            if (k > 0) check("b2b_interval", 64'(cyc - start), 64'(W + 2));
            start = cyc;
            n = 0;
            while (!bus.out_valid && n < 20) begin
                tick();
                n++;
            end
            check("b2b_valid", 64'(bus.out_valid), 64'(1'b1));
            check("b2b_result", 64'({bus.carry_out, bus.sum}), 64'({1'b0, ra} + {1'b0, rb}));
            tick();
        end
        bus.in_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Bit-serial N-bit adder with valid/ready handshakes on both sides. It is the additive counterpart to the clocked subtractor cells in the arithmetic library and reconstructs a minuend from a difference and a subtrahend. Operands are captured in parallel and summed LSB-first, one bit per clock, through a single full-adder cell and a carry flop. The parallel result is then presented to a downstream consumer.

## Interface
- `WIDTH`, default 8: operand and result width; legal range 2..64.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: operands `a`/`b` valid.
- `in_ready` output 1: block can accept operands. High only in IDLE; decoded from state, with no combinational path from `in_valid`.
- `a` input WIDTH: operand A, unsigned or two's complement.
- `b` input WIDTH: operand B.
- `out_valid` output 1: `sum`/`carry_out` valid. High only in DONE.
- `out_ready` input 1: consumer accepts the result.
- `sum` output WIDTH: (a + b) mod 2^WIDTH, registered.
- `carry_out` output 1: carry out of bit WIDTH-1, registered.
- `overflow` output 1: signed overflow flag. Present only with `BIT_SERIAL_ADDER_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready` at an edge: load shift registers `a_sh`←`a` and `b_sh`←`b`, clear the carry flop and the bit counter, then go to RUN.
  - `in_valid` low: stay in IDLE.
- **RUN:**
  - Each edge computes s = `a_sh[0]`^`b_sh[0]`^c and c' = majority(`a_sh[0]`,`b_sh[0]`,c).
  - `a_sh` and `b_sh` shift right by 1. s shifts into the result register from the MSB end, so after WIDTH shifts bit i sits at position i.
  - Counter increments.
  - On the edge that processes bit WIDTH-1: capture c' into `carry_out`, then go to DONE.
  - `in_valid` is ignored. Operand inputs may change freely after capture.
- **DONE:**
  - `out_valid`=1.
  - `sum` and `carry_out` are held stable until `out_ready` is sampled high. Then go to IDLE.
  - `out_valid` is never withdrawn without a handshake.
- `sum` and `carry_out` keep their last values in IDLE and RUN. They are only meaningful while `out_valid`=1.
- Counter width is $clog2(WIDTH+1). No wrap-around: the counter leaves RUN at WIDTH-1.
- Arithmetic: full WIDTH-bit modular addition. For unsigned operands, {`carry_out`,`sum`} = a + b exactly.
- Reset, at any point including mid-RUN or in DONE:
  - state←IDLE.
  - `sum`←0, `carry_out`←0, `overflow`←0, carry flop←0, counter←0, shift registers←0.
  - `out_valid`=0 and `in_ready`=1 in the cycle after the reset edge.
  - Any in-flight operation is discarded with no output.
- `rst` has priority over all handshakes sampled on the same edge.

## Timing
- Operand acceptance edge E0. RUN occupies edges E1..E_WIDTH. `out_valid` rises after edge E_WIDTH, i.e. latency = WIDTH cycles from acceptance.
- Result handshake at edge Ed returns to IDLE. Earliest next acceptance is Ed+1.
- Minimum issue interval is WIDTH+2 cycles, with `out_ready` tied high.
- `out_ready` held low for k cycles extends DONE by k cycles. Nothing else changes.
- `in_valid` and `out_ready` are sampled only in IDLE and DONE respectively. Asserting them in other states has no effect.

## Configuration
- Macro `BIT_SERIAL_ADDER_OVF_EN` controls the signed-overflow output.
- **Defined:**
  - Port `overflow` exists.
  - On the final RUN edge it registers carry-into-MSB XOR carry-out-of-MSB, i.e. set when `a`[MSB]==`b`[MSB] and `sum`[MSB]≠`a`[MSB].
  - Held with `sum` and cleared by reset.
- **Undefined:** port `overflow` and its logic are absent. All other behaviour is identical.

## Test plan
- **Basic sum:** WIDTH=8, a=0x35, b=0x4A, `out_ready`=1.
  - `in_ready` drops after the accepting edge.
  - `out_valid` high exactly 8 cycles later with `sum`=0x7F, `carry_out`=0, `overflow`=0.
- **Carry wrap:** a=0xFF, b=0x01 → `sum`=0x00, `carry_out`=1, `overflow`=0.
- **Signed overflow** (macro defined): a=0x7F, b=0x01 → `sum`=0x80, `carry_out`=0, `overflow`=1.
- **Signed overflow, negative case:** a=0x80, b=0x80 → `sum`=0x00, `carry_out`=1, `overflow`=1.
- **Backpressure:** a=0x12, b=0x34 with `out_ready`=0 for 5 cycles after `out_valid` rises.
  - `sum`=0x46 is stable and `out_valid` stays high throughout.
  - A new `in_valid` with a=0x01, b=0x01 is not accepted (`in_ready`=0).
  - After `out_ready`=1 for one edge: `out_valid`=0 and `in_ready`=1, and the new operands are accepted next cycle.
- **Reset mid-operation:** assert `rst` for one edge 3 cycles after accepting a=0xAA, b=0x55.
  - Next cycle: `in_ready`=1, `out_valid`=0, `sum`=0, `carry_out`=0.
  - `out_valid` does not rise for the aborted operation.
  - The next operation, a=0x0F, b=0x01, yields 0x10 with no stale carry.
- **Back-to-back:** 20 random operand pairs with `in_valid`/`out_ready` tied high.
  - Results match a reference sum.
  - Issue interval is exactly WIDTH+2 = 10 cycles.
